uart_tx: RTL and testbench

//   Serial UART transmitter; the sending end of the line uart_rx samples.

---
 rtl/uart_tx_if.sv | 26 ++
 rtl/uart_tx.sv | 149 ++++++++++++++
 tb/tb_uart_tx.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Handshake bundle between a word producer and the UART transmitter.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tx_start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx;
  logic                  tx_busy;
  logic                  tx_done;

  modport master (
    output tx_start,
    output tx_data,
    input  tx,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// The line output is registered so tx never glitches between bit boundaries.
module uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave bus
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              PAR_INV   = (PARITY_ODD != 0);

  // IDLE: line high, waiting | START/DATA/PARITY/STOP: one bit period each
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [BAUD_W-1:0]     baud_q,  baud_d;
  logic [BIT_W-1:0]      bit_q,   bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q,   par_d;
  logic                  tx_q,    tx_d;
  logic                  busy_q,  busy_d;
  logic                  done_q,  done_d;
  logic                  baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q != S_IDLE) begin
      baud_d = baud_last ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        // tx_data is only looked at here, so an undriven bus cannot reach the line
        if (bus.tx_start) begin
          shift_d = bus.tx_data;
          par_d   = (^bus.tx_data) ^ PAR_INV;
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (baud_last) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (baud_last) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_d[0];
          end
        end
      end
      S_PARITY: begin
        if (baud_last) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx      = tx_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench: four transmitter variants, expected frames queued by stimulus, checked by line monitors.
module tb_uart_tx;
  localparam int CPB = 4;
  localparam int DW  = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_if #(.DATA_WIDTH(DW)) if_a ();
  uart_tx_if #(.DATA_WIDTH(DW)) if_b ();
  uart_tx_if #(.DATA_WIDTH(DW)) if_c ();
  uart_tx_if #(.DATA_WIDTH(DW)) if_d ();

  // a: plain 8N1, b: even parity, c: odd parity, d: two stop bits
  uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
  uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    u_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

  logic          start_w [4];
  logic [DW-1:0] data_w  [4];
  logic          tx_w    [4];
  logic          busy_w  [4];
  logic          done_w  [4];

  assign if_a.tx_start = start_w[0];
  assign if_b.tx_start = start_w[1];
  assign if_c.tx_start = start_w[2];
  assign if_d.tx_start = start_w[3];
  assign if_a.tx_data  = data_w[0];
  assign if_b.tx_data  = data_w[1];
  assign if_c.tx_data  = data_w[2];
  assign if_d.tx_data  = data_w[3];
  assign tx_w[0] = if_a.tx;  assign busy_w[0] = if_a.tx_busy;  assign done_w[0] = if_a.tx_done;
  assign tx_w[1] = if_b.tx;  assign busy_w[1] = if_b.tx_busy;  assign done_w[1] = if_b.tx_done;
  assign tx_w[2] = if_c.tx;  assign busy_w[2] = if_c.tx_busy;  assign done_w[2] = if_c.tx_done;
  assign tx_w[3] = if_d.tx;  assign busy_w[3] = if_d.tx_busy;  assign done_w[3] = if_d.tx_done;

  typedef struct {
    int          acc;
    int          nbits;
    logic [11:0] bits;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];

  function automatic void q_push(int k, exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      2:       q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endfunction

  function automatic exp_t q_pop(int k);
    exp_t e;
    case (k)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      2:       e = q2.pop_front();
      default: e = q3.pop_front();
    endcase
    return e;
  endfunction

  function automatic int q_size(int k);
    int s;
    case (k)
      0:       s = q0.size();
      1:       s = q1.size();
      2:       s = q2.size();
      default: s = q3.size();
    endcase
    return s;
  endfunction

  // line image, bit i = i-th bit period; parity bit p is hand-computed by the caller
  function automatic exp_t mk(int k, logic [7:0] d, logic p, int acc);
    exp_t e;
    int   n;
    e.bits    = '1;
    e.bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < DW; i++) begin
      e.bits[n] = d[i];
      n++;
    end
    if (k == 1 || k == 2) begin
      e.bits[n] = p;
      n++;
    end
    n += (k == 3) ? 2 : 1;
    e.nbits = n;
    e.acc   = acc;
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, expv);
    end
  endtask

  task automatic monitor(int k);
    exp_t e;
    bit   aborted;
    bit   bad_busy;
    bit   done_prev;
    logic seen;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done_prev) begin
        chk($sformatf("d%0d_done_width", k), {31'd0, done_w[k]}, 32'd0);
        done_prev = 1'b0;
      end
      if (rst_n === 1'b1 && tx_w[k] === 1'b0) begin
        if (q_size(k) == 0) begin
          chk($sformatf("d%0d_unexpected_frame_at_%0d", k, cyc), {31'd0, tx_w[k]}, 32'd1);
          for (int n = 0; n < 200 && busy_w[k] !== 1'b0; n++) @(negedge clk);
        end else begin
          e = q_pop(k);
          chk($sformatf("d%0d_accept_cycle", k), cyc, e.acc);
          aborted  = 1'b0;
          bad_busy = 1'b0;
          for (int i = 0; i < e.nbits && !aborted; i++) begin
            seen = e.bits[i];
            for (int j = 0; j < CPB && !aborted; j++) begin
              if (i != 0 || j != 0) @(negedge clk);
              if (rst_n !== 1'b1) begin
                aborted = 1'b1;
              end else begin
                if (tx_w[k] !== e.bits[i]) seen = tx_w[k];
                if (busy_w[k] !== 1'b1 || done_w[k] !== 1'b0) bad_busy = 1'b1;
              end
            end
            if (!aborted)
              chk($sformatf("d%0d_acc%0d_bit%0d", k, e.acc, i), {31'd0, seen}, {31'd0, e.bits[i]});
          end
          if (!aborted) begin
            chk($sformatf("d%0d_busy_in_frame", k), {31'd0, bad_busy}, 32'd0);
            @(negedge clk);
            chk($sformatf("d%0d_done", k), {31'd0, done_w[k]}, 32'd1);
            chk($sformatf("d%0d_busy_at_done", k), {31'd0, busy_w[k]}, 32'd0);
            chk($sformatf("d%0d_tx_at_done", k), {31'd0, tx_w[k]}, 32'd1);
            chk($sformatf("d%0d_done_cycle", k), cyc, e.acc + e.nbits * CPB);
            done_prev = 1'b1;
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);
  initial monitor(3);

  task automatic send(int k, logic [7:0] d, logic p);
    @(negedge clk);
    start_w[k] = 1'b1;
    data_w[k]  = d;
    q_push(k, mk(k, d, p, cyc + 1));
    @(negedge clk);
    start_w[k] = 1'b0;
    data_w[k]  = 'x;
  endtask

  task automatic wait_idle(int k);
    int n;
    n = 0;
    while (busy_w[k] !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk($sformatf("d%0d_idle_timeout", k), {31'd0, busy_w[k]}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, want finish", cyc);
    $fatal(1);
  end

  initial begin
    int  acc1;
    int  n;
    bit  bad;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      start_w[k] = 1'b0;
      data_w[k]  = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("d%0d_rst_tx", k),   {31'd0, tx_w[k]},   32'd1);
      chk($sformatf("d%0d_rst_busy", k), {31'd0, busy_w[k]}, 32'd0);
      chk($sformatf("d%0d_rst_done", k), {31'd0, done_w[k]}, 32'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) data_w[k] = 'x;
    repeat (2) @(negedge clk);

    // plain frame: line 0,1,0,1,0,0,1,0,1,1
    send(0, 8'hA5, 1'b0);
    wait_idle(0);

    // parity: even A5 -> 0, odd 07 -> 0, even 07 -> 1
    send(1, 8'hA5, 1'b0);
    send(2, 8'h07, 1'b0);
    wait_idle(1);
    wait_idle(2);
    send(1, 8'h07, 1'b1);
    wait_idle(1);

    for (int k = 0; k < 4; k++)
      chk($sformatf("d%0d_idle_tx_with_x_data", k), {31'd0, tx_w[k]}, 32'd1);

    // start request while busy must be dropped
    send(0, 8'hA5, 1'b0);
    repeat (10) @(negedge clk);
    start_w[0] = 1'b1;
    data_w[0]  = 8'hFF;
    @(negedge clk);
    start_w[0] = 1'b0;
    wait_idle(0);
    data_w[0] = 'x;

    // back-to-back with tx_start held: second accept lands on the edge ending the done cycle
    @(negedge clk);
    start_w[0] = 1'b1;
    data_w[0]  = 8'h00;
    acc1 = cyc + 1;
    q_push(0, mk(0, 8'h00, 1'b0, acc1));
    q_push(0, mk(0, 8'hFF, 1'b0, acc1 + 41));
    @(negedge clk);
    data_w[0] = 8'hFF;
    n = 0;
    while (done_w[0] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_done_seen", {31'd0, done_w[0]}, 32'd1);
    @(negedge clk);
    start_w[0] = 1'b0;
    data_w[0]  = 'x;
    wait_idle(0);

    // two stop bits
    send(3, 8'hA5, 1'b0);
    wait_idle(3);

    // reset in the middle of the data bits
    send(0, 8'hA5, 1'b0);
    repeat (11) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midframe_rst_tx",   {31'd0, tx_w[0]},   32'd1);
    chk("midframe_rst_busy", {31'd0, busy_w[0]}, 32'd0);
    chk("midframe_rst_done", {31'd0, done_w[0]}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done_w[0] !== 1'b0 || tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad = 1'b1;
    end
    chk("post_reset_idle", {31'd0, bad}, 32'd0);

    for (int k = 0; k < 4; k++)
      chk($sformatf("d%0d_pending_frames", k), q_size(k), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
